// File: rtl/mod_arbiter.sv
// mod_arbiter: round-robin arbiter sharing one pipelined modulo unit among
// N_REQ requesters. Results return in issue order and are routed back to
// their owners through an in-order tag FIFO.
//
// After reset the block sits in FLUSH for MOD_LAT+1 cycles. This lets any
// result of an op issued before reset drain out of the mod unit unseen.
// It then moves to RUN.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req      [N_REQ]    per-requester request, held with operands until granted
//   req_in0  [N_REQ*W]  dividends, requester k at [k*W +: W]
//   req_in1  [N_REQ*W]  divisors, same packing
//   gnt      [N_REQ]    one-hot grant (combinational)
//   mod_en              issue strobe to mod unit, the cycle after gnt
//   mod_in0, mod_in1    issued operands
//   mod_valid, mod_out  result strobe / remainder from mod unit (issue order)
//   rsp_valid [N_REQ]   one-hot result pulse to the owning requester
//   rsp_data, rsp_dz    remainder (0 if divisor was zero), divisor-zero flag
//   err_unexp           sticky: result arrived with nothing outstanding
module mod_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 40,
   parameter int MOD_LAT = 4,
   parameter int MAX_OUT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] req_in0,
   input  logic [N_REQ*W-1:0] req_in1,
   output logic [N_REQ-1:0]   gnt,
   output logic               mod_en,
   output logic [W-1:0]       mod_in0,
   output logic [W-1:0]       mod_in1,
   input  logic               mod_valid,
   input  logic [W-1:0]       mod_out,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [W-1:0]       rsp_data,
   output logic               rsp_dz,
   output logic               err_unexp
);

   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int AW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int FL_W  = $clog2(MOD_LAT + 2);

   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
   localparam logic [FL_W-1:0]  FL_LOAD = FL_W'(MOD_LAT + 1);

   typedef enum logic {S_FLUSH, S_RUN} state_t;

   state_t            state, state_nx;
   logic              run;
   logic [FL_W-1:0]   flush_cnt;

   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   cand;
   logic [ID_W-1:0]   gnt_id;
   logic              gnt_hit;
   logic              grant;
   logic              pop;
   logic [CNT_W-1:0]  count;
   logic [W-1:0]      sel_in0, sel_in1;

   logic [ID_W:0]     tag_mem [MAX_OUT];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [ID_W-1:0]   pop_id;
   logic              pop_dz;
   logic [N_REQ-1:0]  pop_onehot;

   // ---- FSM: state register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FLUSH;
      else     state <= state_nx;
   end

   // ---- FSM: next state; the counter reaches 0 on the edge leaving FLUSH ----
   always_comb begin
      state_nx = state;
      if (state == S_FLUSH && flush_cnt <= FL_W'(1)) state_nx = S_RUN;
   end

   // ---- FSM: outputs ----
   always_comb begin
      run = (state == S_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      flush_cnt <= FL_LOAD;
      else if (state == S_FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - FL_W'(1);
   end

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      gnt_hit = 1'b0;
      gnt_id  = rr_ptr;
      cand    = rr_ptr;
      for (int i = 0; i < N_REQ; i++) begin
         cand = (cand == LAST_ID) ? '0 : cand + ID_W'(1);
         if (!gnt_hit && req[cand]) begin
            gnt_hit = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   // A result popping this cycle frees a slot, so a full FIFO may still grant.
   assign pop   = run && mod_valid && (count != '0);
   assign grant = run && gnt_hit && ((count != MAX_CNT) || pop);

   always_comb begin
      gnt     = '0;
      sel_in0 = '0;
      sel_in1 = '0;
      for (int k = 0; k < N_REQ; k++) begin
         gnt[k] = grant && (gnt_id == ID_W'(k));
         if (gnt_id == ID_W'(k)) begin
            sel_in0 = req_in0[k*W +: W];
            sel_in1 = req_in1[k*W +: W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rr_ptr <= LAST_ID;
      else if (grant) rr_ptr <= gnt_id;
   end

   // ---- issue stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mod_en  <= 1'b0;
         mod_in0 <= '0;
         mod_in1 <= '0;
      end else begin
         mod_en <= grant;
         if (grant) begin
            mod_in0 <= sel_in0;
            mod_in1 <= sel_in1;
         end
      end
   end

   // Tag FIFO. Storage needs no reset: occupancy is tracked by count.
   // With push and pop in the same cycle on a full FIFO, wr_ptr == rd_ptr;
   // the pop reads the old entry before the edge overwrites it.
   always_ff @(posedge clk) begin
      if (grant) tag_mem[wr_ptr] <= {gnt_id, (sel_in1 == '0)};
   end

   assign {pop_id, pop_dz} = tag_mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (grant) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({grant, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      for (int k = 0; k < N_REQ; k++) pop_onehot[k] = (pop_id == ID_W'(k));
   end

   // ---- response stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_dz    <= 1'b0;
         err_unexp <= 1'b0;
      end else begin
         rsp_valid <= pop ? pop_onehot : '0;
         rsp_dz    <= pop && pop_dz;
         if (pop) rsp_data <= pop_dz ? '0 : mod_out;
         if (run && mod_valid && count == '0) err_unexp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mod_arbiter.sv
module tb_mod_arbiter;
   localparam int N_REQ   = 4;
   localparam int W       = 40;
   localparam int MOD_LAT = 4;
   localparam int MAX_OUT = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] req_in0, req_in1;
   logic [N_REQ-1:0]   gnt;
   logic               mod_en;
   logic [W-1:0]       mod_in0, mod_in1;
   logic               mod_valid;
   logic [W-1:0]       mod_out;
   logic [N_REQ-1:0]   rsp_valid;
   logic [W-1:0]       rsp_data;
   logic               rsp_dz;
   logic               err_unexp;

   always #5 clk = ~clk;

   mod_arbiter #(.N_REQ(N_REQ), .W(W), .MOD_LAT(MOD_LAT), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_in0(req_in0), .req_in1(req_in1),
      .gnt(gnt), .mod_en(mod_en), .mod_in0(mod_in0), .mod_in1(mod_in1),
      .mod_valid(mod_valid), .mod_out(mod_out), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_dz(rsp_dz), .err_unexp(err_unexp)
   );

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] data;
      logic         dz;
   } exp_t;

   typedef struct packed {
      logic [31:0]  ready;
      logic [W-1:0] res;
   } mres_t;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_data;
      logic         exp_dz;
   } vec_t;

   exp_t         exp_q[$];
   mres_t        mq[$];
   int           gcq[$];
   int           glog[$];
   int           gtlog[$];
   int           pend[N_REQ];
   logic [W-1:0] a_op[N_REQ];
   logic [W-1:0] b_op[N_REQ];
   int           cyc, checks, failures, ngnt, rel;
   bit           stall, inject, chk_lat, exp_en, err_exp;
   logic [W-1:0] exp_in0, exp_in1, last_data;
   vec_t         tbl[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == '0) ? '0 : a % b;
   endfunction

   task automatic push_exp(input int id, input logic [W-1:0] data, input logic dz);
      exp_t e;
      e.id   = 2'(id);
      e.data = data;
      e.dz   = dz;
      exp_q.push_back(e);
   endtask

   task automatic monitor();
      int           k;
      exp_t         e;
      mres_t        m;
      int           g;
      logic [N_REQ-1:0] oh;
      if (rst) begin
         exp_q.delete();
         gcq.delete();
         exp_en    = 1'b0;
         last_data = '0;
         err_exp   = 1'b0;
      end
      check("err_unexp", err_unexp, err_exp);
      check("mod_en", mod_en, exp_en);
      if (exp_en && mod_en) begin
         check("mod_in0", mod_in0, exp_in0);
         check("mod_in1", mod_in1, exp_in1);
      end
      if (mod_en) begin
         m.ready = 32'(cyc + MOD_LAT);
         m.res   = (mod_in1 == '0) ? '1 : mod_in0 % mod_in1;
         mq.push_back(m);
      end
      check("gnt_legal", 64'($onehot0(gnt) && ((gnt & ~req) == '0)), 64'd1);
      exp_en = 1'b0;
      if (gnt != '0) begin
         k = 0;
         for (int j = 0; j < N_REQ; j++) if (gnt[j]) k = j;
         exp_en  = 1'b1;
         exp_in0 = a_op[k];
         exp_in1 = b_op[k];
         pend[k]--;
         glog.push_back(k);
         gtlog.push_back(cyc);
         gcq.push_back(cyc);
         ngnt++;
      end
      check("rsp_onehot", 64'($onehot0(rsp_valid)), 64'd1);
      if (rsp_valid != '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got rsp_valid=%b expected none (cycle %0d)", rsp_valid, cyc);
         end else begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            check("rsp_id", rsp_valid, oh);
            check("rsp_data", rsp_data, e.data);
            check("rsp_dz", rsp_dz, e.dz);
            last_data = e.data;
         end
         if (gcq.size() > 0) begin
            g = gcq.pop_front();
            if (chk_lat) check("latency", cyc - g, 2 + MOD_LAT);
         end
      end else begin
         check("rsp_dz_idle", rsp_dz, 0);
         check("rsp_data_hold", rsp_data, last_data);
      end
   endtask

   // Called at a negedge: drive inputs and the mod-unit model, sample, advance.
   task automatic cycle();
      for (int k = 0; k < N_REQ; k++) begin
         req[k] = (pend[k] > 0);
         req_in0[k*W +: W] = a_op[k];
         req_in1[k*W +: W] = b_op[k];
      end
      if (inject) begin
         mod_valid = 1'b1;
         mod_out   = W'({$urandom(), $urandom()});
      end else if (!stall && mq.size() > 0 && int'(mq[0].ready) <= cyc) begin
         mod_valid = 1'b1;
         mod_out   = mq[0].res;
         void'(mq.pop_front());
      end else begin
         mod_valid = 1'b0;
      end
      #1;
      monitor();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_until_idle(input string name, input int max);
      bit idle;
      for (int i = 0; i < max; i++) begin
         idle = (exp_q.size() == 0) && (mq.size() == 0) && !exp_en;
         for (int k = 0; k < N_REQ; k++) if (pend[k] > 0) idle = 1'b0;
         if (idle) break;
         cycle();
      end
      idle = (exp_q.size() == 0) && (mq.size() == 0) && !exp_en;
      for (int k = 0; k < N_REQ; k++) if (pend[k] > 0) idle = 1'b0;
      check(name, idle, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bp_order[10];
      int prev;
      tbl[0] = '{2'd2, 40'd17, 40'd5, 40'd2, 1'b0};
      tbl[1] = '{2'd1, 40'd9, 40'd0, 40'd0, 1'b1};
      tbl[2] = '{2'd0, 40'd9, 40'd4, 40'd1, 1'b0};
      tbl[3] = '{2'd3, 40'd100, 40'd7, 40'd2, 1'b0};
      tbl[4] = '{2'd0, 40'hFF_FFFF_FFFF, 40'h10, 40'hF, 1'b0};
      tbl[5] = '{2'd1, 40'd5, 40'd9, 40'd5, 1'b0};
      tbl[6] = '{2'd2, 40'd0, 40'd3, 40'd0, 1'b0};
      tbl[7] = '{2'd3, 40'd12345, 40'd1, 40'd0, 1'b0};
      tbl[8] = '{2'd1, 40'd1000, 40'd999, 40'd1, 1'b0};
      bp_order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};

      cyc = 0; checks = 0; failures = 0; ngnt = 0;
      stall = 0; inject = 0; chk_lat = 0; exp_en = 0; err_exp = 0;
      last_data = '0; exp_in0 = '0; exp_in1 = '0;
      rst = 1'b1; req = '0; req_in0 = '0; req_in1 = '0;
      mod_valid = 1'b0; mod_out = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pend[k] = 0; a_op[k] = '0; b_op[k] = '0;
      end

      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_mod_en", mod_en, 0);
      check("rst_mod_in0", mod_in0, 0);
      check("rst_mod_in1", mod_in1, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_dz", rsp_dz, 0);
      check("rst_err", err_unexp, 0);
      cycle();
      cycle();

      // Fairness: all four request twice, from reset pointer req[0] wins first.
      for (int k = 0; k < N_REQ; k++) begin
         a_op[k] = W'(100 + k);
         b_op[k] = W'(7 + k);
         pend[k] = 2;
      end
      for (int i = 0; i < 8; i++) push_exp(i % 4, ref_mod(W'(100 + i % 4), W'(7 + i % 4)), 1'b0);
      glog.delete(); gtlog.delete(); ngnt = 0; chk_lat = 1;
      rst = 1'b0;
      rel = cyc;
      for (int i = 0; i < 40 && ngnt < 8; i++) cycle();
      check("fair_grants", ngnt, 8);
      if (glog.size() == 8) begin
         check("flush_len", gtlog[0] - rel, MOD_LAT + 1);
         check("fair_span", gtlog[7] - gtlog[0], 7);
         for (int i = 0; i < 8; i++) check("fair_order", glog[i], i % 4);
      end
      run_until_idle("fair_drain", 60);

      // Back-pressure: results stalled, ten ops queued.
      stall = 1; chk_lat = 0;
      pend[0] = 3; pend[1] = 3; pend[2] = 2; pend[3] = 2;
      for (int k = 0; k < N_REQ; k++) begin
         a_op[k] = W'(20 + k);
         b_op[k] = W'(3 + k);
      end
      for (int i = 0; i < 10; i++)
         push_exp(bp_order[i], ref_mod(W'(20 + bp_order[i]), W'(3 + bp_order[i])), 1'b0);
      glog.delete(); gtlog.delete(); ngnt = 0;
      repeat (20) cycle();
      check("bp_stalled_grants", ngnt, MAX_OUT);
      stall = 0;
      cycle();
      stall = 1;
      check("bp_grant_on_pop", ngnt, MAX_OUT + 1);
      repeat (6) cycle();
      check("bp_full_hold", ngnt, MAX_OUT + 1);
      stall = 0;
      run_until_idle("bp_drain", 100);
      check("bp_total", ngnt, 10);
      if (glog.size() == 10)
         for (int i = 0; i < 10; i++) check("bp_order", glog[i], bp_order[i]);

      // Table-driven single ops with end-to-end latency checks.
      chk_lat = 1;
      for (int i = 0; i < 9; i++) begin
         a_op[tbl[i].id] = tbl[i].a;
         b_op[tbl[i].id] = tbl[i].b;
         pend[tbl[i].id] = 1;
         push_exp(int'(tbl[i].id), tbl[i].exp_data, tbl[i].exp_dz);
         run_until_idle("vec_drain", 40);
      end

      // Zero divisor followed by a normal op, responses in order.
      a_op[1] = 40'd9; b_op[1] = 40'd0; pend[1] = 1;
      push_exp(1, 40'd0, 1'b1);
      cycle();
      a_op[0] = 40'd9; b_op[0] = 40'd4; pend[0] = 1;
      push_exp(0, 40'd1, 1'b0);
      run_until_idle("dz_drain", 40);

      // Reset with three ops in flight.
      chk_lat = 0; ngnt = 0;
      for (int k = 0; k < 3; k++) begin
         a_op[k] = W'(50 + k); b_op[k] = 40'd6; pend[k] = 1;
         push_exp(k, ref_mod(W'(50 + k), 40'd6), 1'b0);
      end
      for (int i = 0; i < 20 && ngnt < 3; i++) cycle();
      check("midop_grants", ngnt, 3);
      prev = mq.size();
      check("midop_in_flight", 64'(prev > 0), 64'd1);
      rst = 1'b1;
      a_op[3] = 40'd77; b_op[3] = 40'd10; pend[3] = 1;
      cycle();
      rst = 1'b0;
      push_exp(3, 40'd7, 1'b0);
      rel = cyc; ngnt = 0; gtlog.delete();
      for (int i = 0; i < 20 && ngnt < 1; i++) cycle();
      check("midop_regrant", ngnt, 1);
      if (gtlog.size() == 1) check("midop_flush_len", gtlog[0] - rel, MOD_LAT + 1);
      run_until_idle("midop_drain", 40);

      // Unexpected result while idle in RUN.
      inject = 1;
      cycle();
      inject = 0;
      err_exp = 1'b1;
      repeat (4) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (3) cycle();
      check("final_err", err_unexp, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
